// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter and sequencer for a shared 4:1 data mux.
//               It grants one requester at a time, drives the mux select and
//               forwards that requester's beats to one ready/valid port. A
//               grant lasts up to MAX_BURST beats and is followed by a single
//               IDLE arbitration cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic [3:0]       ack
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;
    // Beat index of the final beat in a burst; the counter is 4 bits wide.
    localparam logic [3:0] c_LAST = 4'(MAX_BURST - 1);

    logic [0:0] r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_cnt;
    logic [1:0] w_winner;
    logic       w_found;
    logic       w_xfer;

    // Valid only while a grant is active and its owner still has a beat.
    assign out_valid = (r_state == c_BUSY) & req[sel];
    assign w_xfer    = out_valid & out_ready;
    assign ack       = grant & {4{w_xfer}};

    // Mux the granted (or last granted) requester's data to the output.
    always_comb begin
        case (sel)
            2'd0:    out_data = d0;
            2'd1:    out_data = d1;
            2'd2:    out_data = d2;
            default: out_data = d3;
        endcase
    end

    // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4) for the first active request.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && req[r_ptr + 2'(k)]) begin
                w_found  = 1'b1;
                w_winner = r_ptr + 2'(k);
            end
        end
    end

    // Arbitration FSM: grant from IDLE, count beats in BUSY, release on
    // burst end or when the owner drops its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            grant   <= 4'b0000;
            sel     <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state <= c_BUSY;
                        sel     <= w_winner;
                        grant   <= 4'b0001 << w_winner;
                        r_cnt   <= 4'd0;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        if (r_cnt == c_LAST) begin
                            r_state <= c_IDLE;
                            grant   <= 4'b0000;
                            r_ptr   <= sel + 2'd1;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end else if (!req[sel]) begin
                        // Owner withdrew: release early so others are not starved.
                        r_state <= c_IDLE;
                        grant   <= 4'b0000;
                        r_ptr   <= sel + 2'd1;
                        r_cnt   <= 4'd0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Scoreboard bench for mux4_rr_arbiter. The driver applies
//               directed and random stimulus, predicts each cycle's outputs
//               from a transaction-level model and queues them; a monitor
//               pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic [3:0]       ack;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       grant;
        logic [1:0]       sel;
        logic             valid;
        logic [3:0]       ack;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_acks   = 0;

    // Reference model: who owns the port, how many beats it has delivered,
    // where the next round-robin search starts and the last winner.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_last  = 0;

    logic [WIDTH-1:0] dv [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, predict the
    // outputs seen for the rest of this cycle, then advance the model to the
    // state the next rising edge produces.
    task automatic cycle(input logic rst, input logic [3:0] r, input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (!r[i]) dv[i] = WIDTH'($urandom);
        d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
        req       = r;
        out_ready = rdy;
        rst_n     = rst;
        if (!rst) begin
            m_owner = -1; m_beats = 0; m_ptr = 0; m_last = 0;
            e.grant = 4'b0000; e.sel = 2'd0; e.valid = 1'b0; e.ack = 4'b0000;
            e.data  = dv[0];
            sb.push_back(e);
        end else begin
            e.sel   = 2'(m_last);
            e.grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            e.valid = (m_owner >= 0) && r[m_owner];
            e.ack   = (e.valid && rdy) ? e.grant : 4'b0000;
            e.data  = dv[m_last];
            sb.push_back(e);
            if (m_owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        m_last  = m_owner;
                        m_beats = 0;
                    end
                end
            end else if (e.valid && rdy) begin
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                    m_beats = 0;
                end
            end else if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_beats = 0;
            end
        end
    endtask

    // Monitor: compare DUT outputs against the queued prediction mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("grant", 32'(grant), 32'(e.grant));
                check("sel", 32'(sel), 32'(e.sel));
                check("out_valid", 32'(out_valid), 32'(e.valid));
                check("ack", 32'(ack), 32'(e.ack));
                if (e.valid) check("out_data", 32'(out_data), 32'(e.data));
                if (ack != 4'b0000) n_acks++;
            end
        end
    end

    // Stimulus: directed scenarios first, then a long random run.
    initial begin
        logic [3:0] r;
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) dv[i] = 8'h00;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;

        // Reset with all requests held, then full-load rotation 0,1,2,3,0.
        repeat (3) cycle(1'b0, 4'b1111, 1'b1);
        repeat (26) cycle(1'b1, 4'b1111, 1'b1);

        // Single requester 2 with a known data pattern.
        repeat (2) cycle(1'b1, 4'b0000, 1'b1);
        dv[2] = 8'hA5;
        repeat (12) cycle(1'b1, 4'b0100, 1'b1);

        // Requester 1 stalled by the sink for several cycles, then drained.
        repeat (2) cycle(1'b1, 4'b0000, 1'b1);
        repeat (4) cycle(1'b1, 4'b0010, 1'b0);
        repeat (6) cycle(1'b1, 4'b0010, 1'b1);

        // Requester 3 withdraws after two beats; requester 0 then wins.
        repeat (2) cycle(1'b1, 4'b0000, 1'b1);
        repeat (3) cycle(1'b1, 4'b1000, 1'b1);
        repeat (4) cycle(1'b1, 4'b0001, 1'b1);

        // Reset in the middle of a burst, then arbitration restarts at 0.
        repeat (2) cycle(1'b1, 4'b0000, 1'b1);
        repeat (3) cycle(1'b1, 4'b0110, 1'b1);
        repeat (2) cycle(1'b0, 4'b0110, 1'b1);
        repeat (12) cycle(1'b1, 4'b1111, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            cycle(($urandom_range(0, 299) != 0), r, ($urandom_range(0, 3) != 0));
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        n_checks++;
        if (n_acks < 100) begin
            n_fail++;
            $display("FAIL ack_activity: got %0d ack cycles expected at least 100", n_acks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
